// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the button event generator:
//   - event type codes (PRESS / LONG / REPEAT / RELEASE)
//   - per-button hold FSM state encoding
//   - packed queued-event record {id, typ}
//   - small constant helper used for counter sizing
// ---------------------------------------------------------------------------
package btn_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_LONG    = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;
    localparam logic [1:0] EVT_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

    // The id field is sized for the largest supported button count (256);
    // the top level only drives/uses the low $clog2(N_BTN) bits.
    localparam int EVT_ID_W_MAX = 8;

    typedef struct packed {
        logic [EVT_ID_W_MAX-1:0] id;
        logic [1:0]              typ;
    } btn_evt_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// ---------------------------------------------------------------------------
// btn_evt_fifo
// Synchronous show-ahead FIFO. The head entry is always visible on pop_data;
// pop removes it. A push while full is accepted only if a pop happens in the
// same cycle (count then stays unchanged). Storage is reset so the head reads
// as zero out of reset.
//
// Parameters: WIDTH (entry width), DEPTH (power of two, >= 2)
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data at the tail
//   push_data  in   WIDTH
//   pop        in   drop the head entry (ignored when empty)
//   pop_data   out  WIDTH, current head entry
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of stored entries
// ---------------------------------------------------------------------------
module btn_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// ---------------------------------------------------------------------------
// btn_event_gen
// Turns debounced button levels into queued PRESS / LONG / REPEAT / RELEASE
// events. Each button runs a small hold-timer FSM that raises per-type
// pending flags; a fixed-priority arbiter (lowest button first, then
// PRESS < LONG < REPEAT < RELEASE) moves one flag per cycle into a
// show-ahead FIFO that is drained over a valid/ready handshake.
//
// Build option:
//   BTN_EVT_REPEAT_EN  when defined, REPEAT events are generated every
//                      REPEAT_CYCLES while a button stays in LONG. When not
//                      defined, LONG is silent until release and the REPEAT
//                      flag and its compare logic do not exist.
//
// Parameters: N_BTN (2..256), LONG_CYCLES (>= 2), REPEAT_CYCLES (>= 2),
//             FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   N_BTN debounced levels, 1 = pressed
//   evt_valid  out  FIFO head valid
//   evt_ready  in   consumer accepts the head
//   evt_id     out  button index of the head event
//   evt_type   out  0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE
//   ovf        out  sticky: an event was lost
//   ovf_clr    in   clears ovf (a simultaneous loss wins)
//
// Per-button FSM
//   state   | meaning
//   IDLE    | button released, waiting for a rising edge
//   HELD    | pressed, counting towards the long-press threshold
//   LONG    | long press reported, counting repeat periods
// ---------------------------------------------------------------------------
module btn_event_gen
    import btn_evt_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_BTN-1:0]          btn_in,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_BTN)-1:0]  evt_id,
    output logic [1:0]                evt_type,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int IDW   = $clog2(N_BTN);
    localparam int CW    = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));
    localparam int NFLAG = 4 * N_BTN;
    localparam int GW    = $clog2(NFLAG);

    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
    localparam logic [3:0]    FLAG_MASK = 4'b1111;
`else
    // REPEAT flag bit is tied off so its flops are removed.
    localparam logic [3:0]    FLAG_MASK = 4'b1011;
`endif

    logic [N_BTN-1:0]          btn_prev_q, btn_prev_d;
    logic [NFLAG-1:0]          pend_q, pend_d;
    logic [NFLAG-1:0]          set_vec;
    logic [NFLAG-1:0]          gnt_vec;
    logic [NFLAG-1:0]          loss_vec;
    logic                      ovf_q, ovf_d;
    logic [GW-1:0]             gnt_idx;
    logic                      gnt_any;
    btn_evt_t                  push_evt;
    btn_evt_t                  head;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      unused_bits;

    assign btn_prev_d = btn_in;

    // -----------------------------------------------------------------------
    // Per-button hold FSM and counter. Flags are laid out as 4 bits per
    // button, indexed by event type, so the flat index doubles as priority.
    // -----------------------------------------------------------------------
    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_state_e    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [3:0]    set_b;
        logic          rise, fall;

        assign rise = btn_in[b] & ~btn_prev_q[b];
        assign fall = ~btn_in[b] & btn_prev_q[b];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            set_b   = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        set_b[EVT_PRESS] = 1'b1;
                        cnt_d            = '0;
                        state_d          = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        set_b[EVT_RELEASE] = 1'b1;
                        cnt_d              = '0;
                        state_d            = ST_IDLE;
                    end else if (btn_in[b]) begin
                        if (cnt_q == LONG_TC) begin
                            set_b[EVT_LONG] = 1'b1;
                            cnt_d           = '0;
                            state_d         = ST_LONG;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        set_b[EVT_RELEASE] = 1'b1;
                        cnt_d              = '0;
                        state_d            = ST_IDLE;
                    end
`ifdef BTN_EVT_REPEAT_EN
                    else if (btn_in[b]) begin
                        if (cnt_q == REPEAT_TC) begin
                            set_b[EVT_REPEAT] = 1'b1;
                            cnt_d             = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign set_vec[4*b +: 4] = set_b & FLAG_MASK;
    end

    // -----------------------------------------------------------------------
    // Arbiter: first set flag in flat order wins, only while FIFO has room.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (!fifo_full) begin
            for (int i = 0; i < NFLAG; i++) begin
                if (!gnt_any && pend_q[i]) begin
                    gnt_vec[i] = 1'b1;
                    gnt_idx    = GW'(i);
                    gnt_any    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_evt     = '0;
        push_evt.id  = EVT_ID_W_MAX'(gnt_idx[GW-1:2]);
        push_evt.typ = gnt_idx[1:0];
    end

    // A set on a flag that is being granted this cycle re-arms it, so only a
    // set on a flag that remains pending counts as a lost event.
    always_comb begin
        loss_vec = set_vec & pend_q & ~gnt_vec;
        pend_d   = ((pend_q & ~gnt_vec) | set_vec) & {N_BTN{FLAG_MASK}};
        ovf_d    = ovf_q;
        if (|loss_vec) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            btn_prev_q <= btn_prev_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

    btn_evt_fifo #(
        .WIDTH ($bits(btn_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (gnt_any),
        .push_data (push_evt),
        .pop       (evt_valid & evt_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_id    = head.id[IDW-1:0];
    assign evt_type  = head.typ;
    assign ovf       = ovf_q;

    // Upper id bits are constant zero at this button count; occupancy is
    // not needed beyond empty/full.
    assign unused_bits = ^{fifo_count, head.id};

endmodule

// File: tb/tb_btn_event_gen.sv
module tb_btn_event_gen;

    localparam int N_BTN = 4;
    localparam int LONGC = 8;
    localparam int REPC  = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_BTN-1:0] btn_in = '0;
    logic             evt_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             evt_valid;
    logic [1:0]       evt_id;
    logic [1:0]       evt_type;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    btn_event_gen #(
        .N_BTN         (N_BTN),
        .LONG_CYCLES   (LONGC),
        .REPEAT_CYCLES (REPC),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int id;
        int typ;
    } ev_t;

    ev_t m_q[$];
    bit  m_prev[N_BTN];
    int  m_press[N_BTN];
    bit  m_pend[N_BTN][4];
    bit  m_new[N_BTN][4];
    bit  m_ovf;
    int  m_cyc;
    int  m_g;
    int  m_age;
    bit  m_full;
    bit  m_loss;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = 0;
            for (int b = 0; b < N_BTN; b++) begin
                m_prev[b]  = 1'b0;
                m_press[b] = 0;
                for (int t = 0; t < 4; t++) m_pend[b][t] = 1'b0;
            end
        end else begin
            m_cyc++;
            m_full = (m_q.size() == DEPTH);
            // events raised this edge, from hold age since the press edge
            for (int b = 0; b < N_BTN; b++) begin
                for (int t = 0; t < 4; t++) m_new[b][t] = 1'b0;
                if (btn_in[b] && !m_prev[b]) begin
                    m_new[b][0] = 1'b1;
                    m_press[b]  = m_cyc;
                end else if (!btn_in[b] && m_prev[b]) begin
                    m_new[b][3] = 1'b1;
                end else if (btn_in[b]) begin
                    m_age = m_cyc - m_press[b];
                    if (m_age == LONGC) m_new[b][1] = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                    if (m_age > LONGC && ((m_age - LONGC) % REPC) == 0) m_new[b][2] = 1'b1;
`endif
                end
                m_prev[b] = btn_in[b];
            end
            // lowest (button, type) pending wins if there is room
            m_g = -1;
            if (!m_full) begin
                for (int i = 0; i < 4 * N_BTN; i++) begin
                    if (m_g < 0 && m_pend[i / 4][i % 4]) m_g = i;
                end
            end
            m_loss = 1'b0;
            for (int i = 0; i < 4 * N_BTN; i++) begin
                if (m_new[i / 4][i % 4] && m_pend[i / 4][i % 4] && i != m_g) m_loss = 1'b1;
            end
            if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
            if (m_g >= 0) begin
                m_pend[m_g / 4][m_g % 4] = 1'b0;
                m_q.push_back('{id: m_g / 4, typ: m_g % 4});
            end
            for (int i = 0; i < 4 * N_BTN; i++) begin
                if (m_new[i / 4][i % 4]) m_pend[i / 4][i % 4] = 1'b1;
            end
            if (m_loss) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", int'(evt_valid), 0);
            chk("rst_id", int'(evt_id), 0);
            chk("rst_type", int'(evt_type), 0);
            chk("rst_ovf", int'(ovf), 0);
        end else begin
            chk("model_valid", int'(evt_valid), (m_q.size() != 0) ? 1 : 0);
            if (m_q.size() != 0) begin
                chk("model_id", int'(evt_id), m_q[0].id);
                chk("model_type", int'(evt_type), m_q[0].typ);
            end
            chk("model_ovf", int'(ovf), int'(m_ovf));
        end
    end

    // ---------------- pop log for literal checks ----------------
    typedef struct {
        int cyc;
        int id;
        int typ;
    } log_t;

    log_t pop_log[$];

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready)
            pop_log.push_back('{cyc: cyc, id: int'(evt_id), typ: int'(evt_type)});
    end

    task automatic chk_log(input string name, input int idx, input int base,
                           input int off, input int id, input int typ);
        if (idx >= pop_log.size()) begin
            chk({name, "_missing"}, pop_log.size(), idx + 1);
        end else begin
            chk({name, "_cyc"}, pop_log[idx].cyc - base, off);
            chk({name, "_id"}, pop_log[idx].id, id);
            chk({name, "_type"}, pop_log[idx].typ, typ);
        end
    endtask

    int exp_off[5];
    int exp_typ[5];
    int n_exp;
    int press_edge;

    initial begin
        // reset state
        tick(3);
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        tick(2);

        // 1. short press on button 2
        btn_in[2] = 1'b1;
        tick(1);
        chk("s1_valid_early", int'(evt_valid), 0);
        tick(1);
        chk("s1_press_valid", int'(evt_valid), 1);
        chk("s1_press_id", int'(evt_id), 2);
        chk("s1_press_type", int'(evt_type), 0);
        tick(1);
        btn_in[2] = 1'b0;
        tick(1);
        chk("s1_gap_valid", int'(evt_valid), 0);
        tick(1);
        chk("s1_rel_valid", int'(evt_valid), 1);
        chk("s1_rel_id", int'(evt_id), 2);
        chk("s1_rel_type", int'(evt_type), 3);
        tick(12);
        chk("s1_no_long", int'(evt_valid), 0);
        chk("s1_ovf", int'(ovf), 0);

        // 2. long hold on button 0 for 20 cycles
        pop_log.delete();
        btn_in[0] = 1'b1;
        press_edge = cyc + 1;
        tick(20);
        btn_in[0] = 1'b0;
        tick(6);
`ifdef BTN_EVT_REPEAT_EN
        n_exp = 5;
        exp_off[0] = 1;  exp_typ[0] = 0;
        exp_off[1] = 9;  exp_typ[1] = 1;
        exp_off[2] = 13; exp_typ[2] = 2;
        exp_off[3] = 17; exp_typ[3] = 2;
        exp_off[4] = 21; exp_typ[4] = 3;
`else
        n_exp = 3;
        exp_off[0] = 1;  exp_typ[0] = 0;
        exp_off[1] = 9;  exp_typ[1] = 1;
        exp_off[2] = 21; exp_typ[2] = 3;
`endif
        chk("s2_count", pop_log.size(), n_exp);
        for (int i = 0; i < n_exp; i++) chk_log("s2_evt", i, press_edge, exp_off[i], 0, exp_typ[i]);

        // 3. simultaneous press 4'b1011
        pop_log.delete();
        btn_in = 4'b1011;
        press_edge = cyc + 1;
        tick(4);
        btn_in = 4'b0000;
        tick(8);
        chk_log("s3_p0", 0, press_edge, 1, 0, 0);
        chk_log("s3_p1", 1, press_edge, 2, 1, 0);
        chk_log("s3_p3", 2, press_edge, 3, 3, 0);

        // 4. backpressure and overflow
        evt_ready = 1'b0;
        for (int b = 0; b < N_BTN; b++) begin
            btn_in[b] = 1'b1;
            tick(3);
            btn_in[b] = 1'b0;
            tick(3);
        end
        chk("s4_full_valid", int'(evt_valid), 1);
        chk("s4_head_id", int'(evt_id), 0);
        chk("s4_head_type", int'(evt_type), 0);
        chk("s4_ovf_clean", int'(ovf), 0);
        btn_in[0] = 1'b1; tick(3); btn_in[0] = 1'b0; tick(3);
        chk("s4_ovf_refill", int'(ovf), 0);
        btn_in[0] = 1'b1; tick(3); btn_in[0] = 1'b0; tick(3);
        chk("s4_ovf_set", int'(ovf), 1);
        tick(5);
        chk("s4_ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("s4_ovf_clr", int'(ovf), 0);
        evt_ready = 1'b1;
        tick(20);
        chk("s4_drained", int'(evt_valid), 0);

        // 5. reset during LONG with button 1 held
        btn_in[1] = 1'b1;
        tick(12);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", int'(evt_valid), 0);
        chk("s5_rst_id", int'(evt_id), 0);
        chk("s5_rst_type", int'(evt_type), 0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("s5_early", int'(evt_valid), 0);
        tick(1);
        chk("s5_press_valid", int'(evt_valid), 1);
        chk("s5_press_id", int'(evt_id), 1);
        chk("s5_press_type", int'(evt_type), 0);
        tick(3);
        btn_in[1] = 1'b0;
        tick(8);

        // 6. handshake stability under stall
        evt_ready = 1'b0;
        btn_in = 4'b1010;
        tick(2);
        btn_in = 4'b0000;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("s6_stall_valid", int'(evt_valid), 1);
            chk("s6_stall_id", int'(evt_id), 1);
            chk("s6_stall_type", int'(evt_type), 0);
        end
        pop_log.delete();
        evt_ready = 1'b1;
        tick(6);
        chk("s6_pops", pop_log.size(), 4);
        if (pop_log.size() >= 1) begin
            press_edge = pop_log[0].cyc;
            chk_log("s6_e0", 0, press_edge, 0, 1, 0);
            chk_log("s6_e1", 1, press_edge, 1, 3, 0);
            chk_log("s6_e2", 2, press_edge, 2, 1, 3);
            chk_log("s6_e3", 3, press_edge, 3, 3, 3);
        end

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_BTN; b++) begin
                if ($urandom_range(0, 19) == 0) btn_in[b] = ~btn_in[b];
            end
            evt_ready = ($urandom_range(0, 9) < 6);
            ovf_clr   = ($urandom_range(0, 29) == 0);
            if (c == 1500) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        btn_in = '0;
        ovf_clr = 1'b0;
        evt_ready = 1'b1;
        tick(30);
        chk("final_drained", int'(evt_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
